// File: rtl/uart_rx_if.sv
// RX FIFO write port between the UART receiver and the receive FIFO.
// The receiver drives the write strobe and data; the FIFO returns its full flag.
interface uart_rx_if;
    logic       full;
    logic       wrEn;
    logic [7:0] din;

    // Receiver side: writes bytes into the FIFO.
    modport master (
        input  full,
        output wrEn,
        output din
    );

    // FIFO side: accepts bytes, reports full.
    modport slave (
        output full,
        input  wrEn,
        input  din
    );
endinterface

// File: rtl/uart_rx.sv
// UART 8N1 receiver with 16x oversampling.
// Writes each good byte into the RX FIFO with a one-cycle wrEn strobe.
// Flags and counts framing errors and FIFO overruns.
// Build option: define UART_RX_MAJORITY_EN to take a 2-of-3 majority of the
// samples at indices 7, 8, 9 (decision at index 9) instead of a single sample
// at index 8.
module uart_rx #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned TICK_COUNT = CLK_FREQ / (BAUD_RATE * OVERSAMPLE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rxData,
    uart_rx_if.master        fifo,
    output logic             busy,
    output logic             frameErr,
    output logic             overrun,
    output logic [7:0]       errCount
);

    localparam logic [15:0] TICK_LAST = 16'(TICK_COUNT - 1);
    localparam logic [3:0]  LAST_IDX  = 4'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [3:0]  DECIDE_IDX = 4'd9;
`else
    localparam logic [3:0]  DECIDE_IDX = 4'd8;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_t;

    state_t      state;
    logic        rxMeta;
    logic        rxS;
    logic [15:0] tickCnt;
    logic        tick;
    logic [3:0]  sampCnt;
    logic [2:0]  bitCnt;
    logic [7:0]  shiftReg;
    logic        bitVal;
    logic        decide;
    logic        lastIdx;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxMeta <= 1'b1;
            rxS    <= 1'b1;
        end else begin
            rxMeta <= rxData;
            rxS    <= rxMeta;
        end
    end

    assign tick = (tickCnt == TICK_LAST);

    // Free-running sample-tick divider.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tickCnt <= 16'd0;
        end else if (tick) begin
            tickCnt <= 16'd0;
        end else begin
            tickCnt <= tickCnt + 16'd1;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic samp7;
    logic samp8;

    // Capture the two early samples; the third is the live value at index 9.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp7 <= 1'b1;
            samp8 <= 1'b1;
        end else if (tick && sampCnt == 4'd7) begin
            samp7 <= rxS;
        end else if (tick && sampCnt == 4'd8) begin
            samp8 <= rxS;
        end
    end

    assign bitVal = (samp7 & samp8) | (samp7 & rxS) | (samp8 & rxS);
`else
    assign bitVal = rxS;
`endif

    assign decide  = tick && (sampCnt == DECIDE_IDX);
    assign lastIdx = tick && (sampCnt == LAST_IDX);
    assign busy    = (state != StIdle);

    // Frame FSM with registered FIFO strobe, error pulses and error counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            sampCnt   <= 4'd0;
            bitCnt    <= 3'd0;
            shiftReg  <= 8'h00;
            fifo.wrEn <= 1'b0;
            fifo.din  <= 8'h00;
            frameErr  <= 1'b0;
            overrun   <= 1'b0;
            errCount  <= 8'h00;
        end else begin
            fifo.wrEn <= 1'b0;
            frameErr  <= 1'b0;
            overrun   <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (tick && !rxS) begin
                        state   <= StStart;
                        sampCnt <= 4'd0;
                    end
                end
                StStart: begin
                    if (tick) begin
                        sampCnt <= sampCnt + 4'd1;
                        if (decide && bitVal) begin
                            // Line went back high mid start bit: treat as a glitch.
                            state <= StIdle;
                        end else if (lastIdx) begin
                            state  <= StData;
                            bitCnt <= 3'd0;
                        end
                    end
                end
                StData: begin
                    if (tick) begin
                        sampCnt <= sampCnt + 4'd1;
                        if (decide) begin
                            shiftReg <= {bitVal, shiftReg[7:1]};
                        end
                        if (lastIdx) begin
                            if (bitCnt == 3'd7) begin
                                state <= StStop;
                            end else begin
                                bitCnt <= bitCnt + 3'd1;
                            end
                        end
                    end
                end
                StStop: begin
                    if (tick) begin
                        sampCnt <= sampCnt + 4'd1;
                        // Leave mid stop bit so a start bit right after is caught.
                        if (decide) begin
                            if (!bitVal) begin
                                frameErr <= 1'b1;
                                state    <= StBreak;
                                if (errCount != 8'hFF) begin
                                    errCount <= errCount + 8'd1;
                                end
                            end else if (fifo.full) begin
                                overrun <= 1'b1;
                                state   <= StIdle;
                                if (errCount != 8'hFF) begin
                                    errCount <= errCount + 8'd1;
                                end
                            end else begin
                                fifo.din  <= shiftReg;
                                fifo.wrEn <= 1'b1;
                                state     <= StIdle;
                            end
                        end
                    end
                end
                StBreak: begin
                    if (tick && rxS) begin
                        state <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: serial stimulus with a scoreboard of expected
// FIFO-side events (write, overrun, frame error) checked as they appear.
module tb_uart_rx;

    // 4 clk per tick, 64 clk per bit.
    localparam int unsigned CLK_FREQ  = 614_400;
    localparam int unsigned BAUD_RATE = 9600;
    localparam int BIT_CLKS = 64;

    localparam logic [1:0] EvWrite   = 2'd0;
    localparam logic [1:0] EvOverrun = 2'd1;
    localparam logic [1:0] EvFrame   = 2'd2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxData = 1'b1;
    logic       busy;
    logic       frameErr;
    logic       overrun;
    logic [7:0] errCount;

    uart_rx_if fifoIf ();

    uart_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rxData   (rxData),
        .fifo     (fifoIf.master),
        .busy     (busy),
        .frameErr (frameErr),
        .overrun  (overrun),
        .errCount (errCount)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int wrCnt  = 0;
    int ovCnt  = 0;
    int feCnt  = 0;

    // {kind, expected din}
    logic [9:0] sbQ[$];
    logic [9:0] mon;
    logic [1:0] kindNow;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic expectEv(input logic [1:0] kind, input logic [7:0] data);
        sbQ.push_back({kind, data});
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sendBit(input logic b, input int bits);
        rxData = b;
        repeat (BIT_CLKS * bits) @(negedge clk);
    endtask

    task automatic sendByte(input logic [7:0] b);
        sendBit(1'b0, 1);
        for (int i = 0; i < 8; i++) sendBit(b[i], 1);
        sendBit(1'b1, 1);
    endtask

    // Scoreboard: every strobe or error pulse must match the next expected event.
    always @(negedge clk) begin
        if (!rst && (fifoIf.wrEn || overrun || frameErr)) begin
            check("pulse_exclusive",
                  32'(fifoIf.wrEn) + 32'(overrun) + 32'(frameErr), 32'd1);
            kindNow = fifoIf.wrEn ? EvWrite : (overrun ? EvOverrun : EvFrame);
            if (fifoIf.wrEn) wrCnt++;
            if (overrun) ovCnt++;
            if (frameErr) feCnt++;
            if (sbQ.size() == 0) begin
                check("unexpected_event", 32'(kindNow) + 32'd1, 32'd0);
            end else begin
                mon = sbQ.pop_front();
                check("event_kind", 32'(kindNow), 32'(mon[9:8]));
                check("event_din", 32'(fifoIf.din), 32'(mon[7:0]));
            end
        end
    end

    initial begin
        fifoIf.full = 1'b0;
        rst = 1'b1;
        rxData = 1'b1;
        idle(5);
        check("rst_wrEn", 32'(fifoIf.wrEn), 32'd0);
        check("rst_din", 32'(fifoIf.din), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frameErr", 32'(frameErr), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_errCount", 32'(errCount), 32'd0);
        rst = 1'b0;
        idle(40);

        // Reset asserted while idle.
        rst = 1'b1;
        idle(2);
        check("idle_rst_busy", 32'(busy), 32'd0);
        check("idle_rst_errCount", 32'(errCount), 32'd0);
        check("idle_rst_din", 32'(fifoIf.din), 32'h00);
        rst = 1'b0;
        idle(20);

        // Clean byte.
        expectEv(EvWrite, 8'hA5);
        sendByte(8'hA5);
        idle(8);
        check("a5_wrCnt", 32'(wrCnt), 32'd1);
        check("a5_feCnt", 32'(feCnt), 32'd0);
        check("a5_ovCnt", 32'(ovCnt), 32'd0);
        check("a5_din", 32'(fifoIf.din), 32'hA5);
        check("a5_busy", 32'(busy), 32'd0);

        // FIFO full at the stop decision: overrun, din keeps 0xA5.
        fifoIf.full = 1'b1;
        expectEv(EvOverrun, 8'hA5);
        sendByte(8'h3C);
        fifoIf.full = 1'b0;
        idle(8);
        check("ovr_wrCnt", 32'(wrCnt), 32'd1);
        check("ovr_ovCnt", 32'(ovCnt), 32'd1);
        check("ovr_errCount", 32'(errCount), 32'd1);
        check("ovr_din", 32'(fifoIf.din), 32'hA5);

        // 0x00 with the stop bit held low for two bit times.
        expectEv(EvFrame, 8'hA5);
        sendBit(1'b0, 1);
        for (int i = 0; i < 8; i++) sendBit(1'b0, 1);
        sendBit(1'b0, 2);
        check("brk_busy_low", 32'(busy), 32'd1);
        check("brk_feCnt", 32'(feCnt), 32'd1);
        check("brk_wrCnt", 32'(wrCnt), 32'd1);
        rxData = 1'b1;
        idle(16);
        check("brk_busy_high", 32'(busy), 32'd0);
        check("brk_errCount", 32'(errCount), 32'd2);
        expectEv(EvWrite, 8'h55);
        sendByte(8'h55);
        idle(8);
        check("post_brk_wrCnt", 32'(wrCnt), 32'd2);
        check("post_brk_din", 32'(fifoIf.din), 32'h55);

        // Three-tick low glitch on an idle line.
        rxData = 1'b0;
        idle(12);
        rxData = 1'b1;
        idle(2 * BIT_CLKS);
        check("glitch_busy", 32'(busy), 32'd0);
        check("glitch_wrCnt", 32'(wrCnt), 32'd2);
        check("glitch_errCount", 32'(errCount), 32'd2);

        // Back-to-back frames with a single stop bit.
        expectEv(EvWrite, 8'h00);
        expectEv(EvWrite, 8'hFF);
        sendByte(8'h00);
        sendByte(8'hFF);
        idle(8);
        check("b2b_wrCnt", 32'(wrCnt), 32'd4);
        check("b2b_din", 32'(fifoIf.din), 32'hFF);

        // Reset in the middle of data bit 4 of 0x81.
        sendBit(1'b0, 1);
        for (int i = 0; i < 4; i++) sendBit(((8'h81 >> i) & 8'h01) != 8'h00, 1);
        rxData = 1'b0;
        idle(BIT_CLKS / 2);
        rst = 1'b1;
        idle(3);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_errCount", 32'(errCount), 32'd0);
        check("mid_rst_wrEn", 32'(fifoIf.wrEn), 32'd0);
        rxData = 1'b1;
        rst = 1'b0;
        idle(2 * BIT_CLKS);
        check("mid_rst_wrCnt", 32'(wrCnt), 32'd4);
        expectEv(EvWrite, 8'h81);
        sendByte(8'h81);
        idle(8);
        check("after_rst_wrCnt", 32'(wrCnt), 32'd5);
        check("after_rst_din", 32'(fifoIf.din), 32'h81);
        check("after_rst_errCount", 32'(errCount), 32'd0);
        check("scoreboard_empty", 32'(sbQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART link: oversamples the incoming RS-232 line at 16x baud, reassembles 8N1 frames and writes each received byte into the receive FIFO through a single-cycle write strobe. It sits between the board RX pin and the RX FIFO write port, mirroring the transmit path that drains the TX FIFO. Framing errors and FIFO overruns are flagged and counted for the host status path.

## Interface
- CLK_FREQ, 50_000_000, system clock frequency in Hz
- BAUD_RATE, 9600, line rate in bit/s
- OVERSAMPLE, 16, sample ticks per bit (fixed; other values unsupported)
- TICK_COUNT, CLK_FREQ/(BAUD_RATE*OVERSAMPLE), clk cycles per sample tick (325 at defaults, truncated)

- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- rxData  input  1  raw serial line, idle high, asynchronous to clk
- full  input  1  RX FIFO full
- wrEn  output  1  FIFO write strobe, one clk cycle per accepted byte
- din  output  8  received byte, FIFO write data
- busy  output  1  high while a frame is being received (state != IDLE)
- frameErr  output  1  one-clk pulse on bad stop bit
- overrun  output  1  one-clk pulse when a good byte is dropped because full=1
- errCount  output  8  saturating count of frameErr + overrun events

## Operation
- Input sync: 2-flop synchronizer on rxData, both flops reset to 1; all decisions use the synchronized value rxS.
- Tick generator: 16-bit counter, free-running from reset; tick high for one clk when counter == TICK_COUNT-1, then counter clears.
- sampCnt: 4-bit, counts ticks within a bit, index 0..15, wraps 15->0 advancing to next bit. bitCnt: 3-bit data bit index.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE: on a tick with rxS==0 -> START, sampCnt=0 (index 0 of start bit).
- START: at decision point, rxS low -> continue; rxS high -> false start, back to IDLE. At index 15 -> DATA, bitCnt=0.
- DATA: at decision point shift sample into shift register LSB first; at index 15, bitCnt==7 -> STOP else bitCnt++.
- STOP: at decision point: sample 1 and full==0 -> din<=shift, wrEn pulse, IDLE. Sample 1 and full==1 -> overrun pulse, din unchanged, no wrEn, IDLE. Sample 0 -> frameErr pulse, no write, BREAK.
- BREAK: stay until a tick with rxS==1, then IDLE.
- Return to IDLE at stop decision (mid stop bit) so back-to-back frames with one stop bit are received.
- errCount increments once per frameErr or overrun pulse; holds at 255.

## Timing
- Reset values: wrEn=0, din=0x00, busy=0, frameErr=0, overrun=0, errCount=0; state IDLE, tick counter 0.
- Decision point: index 8 (single sample), or index 9 when majority enabled (see Configuration).
- wrEn/frameErr/overrun are asserted in the clk cycle after the decision tick, for exactly one clk; mutually exclusive.
- din updates in the same cycle wrEn asserts and holds until the next write.
- full is sampled in the decision-tick cycle only; changes elsewhere are ignored.
- Input latency: 2 clk synchronizer plus up to one tick of start detection jitter.
- rst mid-frame: immediate return to IDLE, partial byte discarded, no strobe, errCount cleared.

## Configuration
- UART_RX_MAJORITY_EN defined: samples rxS at indices 7, 8, 9; bit value is 2-of-3 majority; decision at index 9. Applies to start, data and stop bits.
- Not defined: single sample at index 8, decision at index 8.

## Test plan
- Reset: assert rst mid-idle -> all outputs at reset values, errCount=0, busy=0.
- Send 0xA5 at 9600 baud, full=0 -> exactly one wrEn pulse, din=0xA5, frameErr=overrun=0.
- Send 0x3C with full=1 at stop decision -> no wrEn, one overrun pulse, din keeps previous value, errCount=1.
- Send 0x00 with stop bit held low for 2 bit times -> one frameErr pulse, no wrEn, busy until line high, then next frame 0x55 received correctly.
- Drive 3-tick low glitch on idle line -> no wrEn, no error, state back to IDLE; back-to-back 0x00,0xFF frames -> two wrEn pulses, din 0x00 then 0xFF.
- Assert rst during DATA bit 4 of 0x81 -> no wrEn; following clean 0x81 frame received correctly.
